// File: rtl/isp_blc_if.sv
// Raw Bayer video stream: line valid, frame sync and one pixel per cycle.
// The producer uses the master modport and the consumer uses the slave modport.
interface isp_blc_if #(
    parameter int unsigned BITS = 8
) ();
    logic            href;
    logic            vsync;
    logic [BITS-1:0] raw;

    modport master (output href, output vsync, output raw);
    modport slave  (input  href, input  vsync, input  raw);
endinterface

// File: rtl/isp_blc.sv
// Black level correction with an optional Q4.8 linearisation gain, ahead of white balance.
// Config is shadowed at each vsync rising edge. The pipeline has a fixed 3-cycle latency and never stalls.
module isp_blc #(
    parameter int unsigned BITS   = 8,
    parameter int unsigned WIDTH  = 1280,
    parameter int unsigned HEIGHT = 960,
    parameter int unsigned BAYER  = 0
) (
    input  logic            pclk,
    input  logic            rst,
    input  logic            blc_en,
    input  logic [BITS-1:0] blc_r,
    input  logic [BITS-1:0] blc_gr,
    input  logic [BITS-1:0] blc_gb,
    input  logic [BITS-1:0] blc_b,
    input  logic            lin_en,
    input  logic [11:0]     lin_gain,
    isp_blc_if.slave        vin,
    isp_blc_if.master       vout
);
    localparam int unsigned GW = 12;
    localparam int unsigned PW = BITS + GW;
    localparam int unsigned SW = PW - 8;
    localparam logic [1:0]  PHASE = 2'(BAYER);

    // Frame geometry is descriptive only; the datapath never counts pixels.
    if (WIDTH == 0 || HEIGHT == 0) begin : g_no_geometry
    end

    logic            vs_q;
    logic            vs_rise;
    logic            blc_en_q;
    logic            lin_en_q;
    logic [BITS-1:0] blc_r_q;
    logic [BITS-1:0] blc_gr_q;
    logic [BITS-1:0] blc_gb_q;
    logic [BITS-1:0] blc_b_q;
    logic [GW-1:0]   lin_gain_q;

    assign vs_rise = vin.vsync & ~vs_q;

    // Config shadows: pixels sampled on the load edge still see the old values.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            vs_q       <= 1'b0;
            blc_en_q   <= 1'b0;
            lin_en_q   <= 1'b0;
            blc_r_q    <= '0;
            blc_gr_q   <= '0;
            blc_gb_q   <= '0;
            blc_b_q    <= '0;
            lin_gain_q <= '0;
        end else begin
            vs_q <= vin.vsync;
            if (vs_rise) begin
                blc_en_q   <= blc_en;
                lin_en_q   <= lin_en;
                blc_r_q    <= blc_r;
                blc_gr_q   <= blc_gr;
                blc_gb_q   <= blc_gb;
                blc_b_q    <= blc_b;
                lin_gain_q <= lin_gain;
            end
        end
    end

    logic       odd_pix_q;
    logic       odd_line_q;
    logic [2:0] href_q;
    logic [2:0] vsync_q;

    // Bayer parity and sync delay lines; href_q[0] also serves as the line-end detector.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            odd_pix_q  <= 1'b0;
            odd_line_q <= 1'b0;
            href_q     <= '0;
            vsync_q    <= '0;
        end else begin
            odd_pix_q <= vin.href ? ~odd_pix_q : 1'b0;
            if (vin.vsync) begin
                odd_line_q <= 1'b0;
            end else if (href_q[0] & ~vin.href) begin
                odd_line_q <= ~odd_line_q;
            end
            href_q  <= {href_q[1:0], vin.href};
            vsync_q <= {vsync_q[1:0], vin.vsync};
        end
    end

    logic [1:0]      fmt;
    logic [BITS-1:0] off_d;

    always_comb begin
        fmt   = PHASE ^ {odd_line_q, odd_pix_q};
        off_d = '0;
        if (blc_en_q) begin
            case (fmt)
                2'd0:    off_d = blc_r_q;
                2'd1:    off_d = blc_gr_q;
                2'd2:    off_d = blc_gb_q;
                default: off_d = blc_b_q;
            endcase
        end
    end

    logic [BITS-1:0] d1_q;
    logic [BITS-1:0] off1_q;
    logic [BITS-1:0] d2_q;
    logic [BITS-1:0] d2_d;
    logic [BITS-1:0] d3_d;
    logic [BITS-1:0] raw_q;
    logic [PW-1:0]   prod;
    logic [SW-1:0]   scaled;

    // Clamped subtraction, then the truncating Q4.8 gain with saturation at full scale.
    always_comb begin
        d2_d   = (d1_q < off1_q) ? '0 : d1_q - off1_q;
        prod   = PW'(d2_q) * PW'(lin_gain_q);
        scaled = SW'(prod >> 8);
        d3_d   = d2_q;
        if (lin_en_q) begin
            d3_d = (|scaled[SW-1:BITS]) ? '1 : scaled[BITS-1:0];
        end
    end

    // The last stage register holds the masked pixel directly, so out_raw is 0 whenever out_href is low.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            d1_q   <= '0;
            off1_q <= '0;
            d2_q   <= '0;
            raw_q  <= '0;
        end else begin
            d1_q   <= vin.raw;
            off1_q <= off_d;
            d2_q   <= d2_d;
            raw_q  <= href_q[1] ? d3_d : '0;
        end
    end

    assign vout.href  = href_q[2];
    assign vout.vsync = vsync_q[2];
    assign vout.raw   = raw_q;
endmodule

// File: tb/tb_isp_blc.sv
// Directed bench for isp_blc: a vector table of per-frame configs and pixels plus hand-written
// reset, shadowing and Bayer-phase sequences; a 3-deep model pipe aligns expected values.
module tb_isp_blc;
    localparam int unsigned BITS = 8;

    typedef logic [3:0][BITS-1:0] px4_t;

    typedef struct {
        logic            en;
        logic [BITS-1:0] r;
        logic [BITS-1:0] gr;
        logic [BITS-1:0] gb;
        logic [BITS-1:0] b;
        logic            len;
        logic [11:0]     gain;
        px4_t            raw0;
        px4_t            exp0;
        px4_t            raw1;
        px4_t            exp1;
        string           name;
    } vec_t;

    typedef struct {
        logic            href;
        logic            vsync;
        logic [BITS-1:0] raw0;
        logic [BITS-1:0] raw3;
        logic            chk3;
        string           tag;
    } exp_t;

    logic            pclk = 1'b0;
    logic            rst  = 1'b1;
    logic            blc_en;
    logic            lin_en;
    logic [BITS-1:0] blc_r;
    logic [BITS-1:0] blc_gr;
    logic [BITS-1:0] blc_gb;
    logic [BITS-1:0] blc_b;
    logic [11:0]     lin_gain;

    exp_t pipe [3];
    vec_t vecs [9];
    int   tests = 0;
    int   fails = 0;

    always #5 pclk = ~pclk;

    isp_blc_if #(.BITS(BITS)) vin   ();
    isp_blc_if #(.BITS(BITS)) vout0 ();
    isp_blc_if #(.BITS(BITS)) vout3 ();

    isp_blc #(.BITS(BITS), .WIDTH(1280), .HEIGHT(960), .BAYER(0)) u_dut0 (
        .pclk(pclk), .rst(rst), .blc_en(blc_en), .blc_r(blc_r), .blc_gr(blc_gr),
        .blc_gb(blc_gb), .blc_b(blc_b), .lin_en(lin_en), .lin_gain(lin_gain),
        .vin(vin), .vout(vout0)
    );

    isp_blc #(.BITS(BITS), .WIDTH(1280), .HEIGHT(960), .BAYER(3)) u_dut3 (
        .pclk(pclk), .rst(rst), .blc_en(blc_en), .blc_r(blc_r), .blc_gr(blc_gr),
        .blc_gb(blc_gb), .blc_b(blc_b), .lin_en(lin_en), .lin_gain(lin_gain),
        .vin(vin), .vout(vout3)
    );

    function automatic px4_t px4(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic vec_t mk(input int en, input int r, input int gr, input int gb, input int b,
                                input int len, input int gain, input px4_t r0, input px4_t e0,
                                input px4_t r1, input px4_t e1, input string nm);
        vec_t v;
        v.en = 1'(en); v.r = 8'(r); v.gr = 8'(gr); v.gb = 8'(gb); v.b = 8'(b);
        v.len = 1'(len); v.gain = 12'(gain);
        v.raw0 = r0; v.exp0 = e0; v.raw1 = r1; v.exp1 = e1; v.name = nm;
        return v;
    endfunction

    task automatic set_cfg(input vec_t v);
        blc_en = v.en; blc_r = v.r; blc_gr = v.gr; blc_gb = v.gb; blc_b = v.b;
        lin_en = v.len; lin_gain = v.gain;
    endtask

    task automatic check_out();
        tests++;
        if (vout0.href !== pipe[2].href || vout0.vsync !== pipe[2].vsync || vout0.raw !== pipe[2].raw0) begin
            fails++;
            $display("FAIL %s bayer0: got href=%b vsync=%b raw=%0d, expected href=%b vsync=%b raw=%0d",
                     pipe[2].tag, vout0.href, vout0.vsync, vout0.raw,
                     pipe[2].href, pipe[2].vsync, pipe[2].raw0);
        end
        if (pipe[2].chk3) begin
            tests++;
            if (vout3.href !== pipe[2].href || vout3.raw !== pipe[2].raw3) begin
                fails++;
                $display("FAIL %s bayer3: got href=%b raw=%0d, expected href=%b raw=%0d",
                         pipe[2].tag, vout3.href, vout3.raw, pipe[2].href, pipe[2].raw3);
            end
        end
    endtask

    // Drive one pixel slot at the falling edge, push its expectation, check the output 3 edges later.
    task automatic cycle(input logic h, input logic v, input logic [BITS-1:0] raw,
                         input logic [BITS-1:0] e0, input logic [BITS-1:0] e3,
                         input logic c3, input string tag);
        exp_t e;
        vin.href = h; vin.vsync = v; vin.raw = raw;
        @(posedge pclk);
        e.href = h; e.vsync = v; e.raw0 = h ? e0 : '0; e.raw3 = h ? e3 : '0; e.chk3 = c3; e.tag = tag;
        pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = e;
        @(negedge pclk);
        check_out();
    endtask

    task automatic line4(input px4_t r, input px4_t e0, input px4_t e3, input logic c3, input string tag);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, r[i], e0[i], e3[i], c3, tag);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 8'hA5, 8'h00, 8'h00, c3, {tag, "_blank"});
    endtask

    task automatic frame_start();
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 8'h5A, 8'h00, 8'h00, 1'b0, "vsync");
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, "vblank");
    endtask

    task automatic clear_pipe();
        for (int i = 0; i < 3; i++) pipe[i] = '{1'b0, 1'b0, 8'd0, 8'd0, 1'b0, "reset"};
    endtask

    initial begin
        vec_t cfg;
        clear_pipe();
        vin.href = 1'b0; vin.vsync = 1'b0; vin.raw = '0;

        vecs[0] = mk(1, 16, 8, 8, 32, 0, 'h100, px4(100, 100, 100, 100), px4(84, 92, 84, 92),
                     px4(100, 100, 100, 100), px4(92, 68, 92, 68), "blc_basic");
        vecs[1] = mk(1, 16, 8, 8, 32, 0, 'h100, px4(5, 7, 16, 9), px4(0, 0, 0, 1),
                     px4(8, 32, 9, 33), px4(0, 0, 1, 1), "underflow");
        vecs[2] = mk(1, 16, 8, 8, 32, 0, 'h100, px4(17, 255, 255, 0), px4(1, 247, 239, 0),
                     px4(255, 255, 7, 31), px4(247, 223, 0, 0), "blc_edges");
        vecs[3] = mk(1, 16, 8, 8, 32, 1, 'h110, px4(255, 100, 16, 0), px4(253, 97, 0, 0),
                     px4(100, 100, 255, 32), px4(97, 72, 255, 0), "lin_1p0625");
        vecs[4] = mk(1, 16, 8, 8, 32, 1, 'h200, px4(200, 100, 0, 0), px4(255, 184, 0, 0),
                     px4(100, 60, 130, 160), px4(184, 56, 244, 255), "lin_2p0_clip");
        vecs[5] = mk(1, 16, 8, 8, 32, 1, 'h000, px4(100, 100, 255, 17), px4(0, 0, 0, 0),
                     px4(100, 100, 255, 40), px4(0, 0, 0, 0), "lin_zero_gain");
        vecs[6] = mk(1, 255, 255, 255, 255, 0, 'h100, px4(255, 254, 0, 128), px4(0, 0, 0, 0),
                     px4(255, 1, 200, 77), px4(0, 0, 0, 0), "blc_full_scale");
        vecs[7] = mk(0, 16, 8, 8, 32, 0, 'h100, px4(1, 2, 3, 4), px4(1, 2, 3, 4),
                     px4(250, 251, 252, 253), px4(250, 251, 252, 253), "blc_disabled");
        vecs[8] = mk(0, 16, 8, 8, 32, 1, 'h080, px4(201, 3, 255, 0), px4(100, 1, 127, 0),
                     px4(100, 101, 2, 1), px4(50, 50, 1, 0), "lin_half");

        // Config is already valid while reset is held; it must not take effect without a vsync.
        set_cfg(vecs[0]);
        @(negedge pclk);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h33, 8'h00, 8'h00, 1'b0, "reset_state");
        rst = 1'b0;
        line4(px4(10, 20, 30, 40), px4(10, 20, 30, 40), '0, 1'b0, "bypass_after_reset");

        // Async reset mid-line must zero the outputs within the same cycle.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'(11 * (i + 1)), 8'(11 * (i + 1)), 8'h00, 1'b0, "bypass_line");
        vin.href = 1'b1; vin.raw = 8'd99;
        @(posedge pclk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if (vout0.href !== 1'b0 || vout0.vsync !== 1'b0 || vout0.raw !== 8'd0) begin
            fails++;
            $display("FAIL async_reset: got href=%b vsync=%b raw=%0d, expected all 0",
                     vout0.href, vout0.vsync, vout0.raw);
        end
        clear_pipe();
        vin.href = 1'b0; vin.raw = '0;
        @(negedge pclk);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, "reset_hold");
        rst = 1'b0;
        line4(px4(50, 60, 70, 80), px4(50, 60, 70, 80), '0, 1'b0, "bypass_held");

        for (int k = 0; k < 9; k++) begin
            set_cfg(vecs[k]);
            frame_start();
            line4(vecs[k].raw0, vecs[k].exp0, '0, 1'b0, {vecs[k].name, "_l0"});
            line4(vecs[k].raw1, vecs[k].exp1, '0, 1'b0, {vecs[k].name, "_l1"});
        end

        // Mid-frame config change is ignored until the next vsync.
        set_cfg(vecs[0]);
        frame_start();
        line4(px4(100, 100, 100, 100), px4(84, 92, 84, 92), '0, 1'b0, "shadow_l0");
        blc_r = 8'd40;
        line4(px4(100, 100, 100, 100), px4(92, 68, 92, 68), '0, 1'b0, "shadow_l1");
        line4(px4(100, 100, 100, 100), px4(84, 92, 84, 92), '0, 1'b0, "shadow_l2_old");
        frame_start();
        line4(px4(100, 100, 100, 100), px4(60, 92, 60, 92), '0, 1'b0, "shadow_next_frame");
        // Config change coincident with the vsync rising edge.
        blc_r = 8'd20;
        frame_start();
        line4(px4(100, 100, 100, 100), px4(80, 92, 80, 92), '0, 1'b0, "shadow_same_edge");

        // Bayer phase: BAYER=3 starts on B, BAYER=0 on R.
        cfg = mk(1, 0, 0, 0, 50, 0, 'h100, '0, '0, '0, '0, "phase");
        set_cfg(cfg);
        frame_start();
        line4(px4(100, 100, 100, 100), px4(100, 100, 100, 100), px4(50, 100, 50, 100), 1'b1, "phase_l0");
        line4(px4(100, 100, 100, 100), px4(100, 50, 100, 50), px4(100, 100, 100, 100), 1'b1, "phase_l1");

        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b1, "flush");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
